// File: rtl/hazard_fwd_tracker.sv
// Producer scoreboard for the pipelined core: tracks GPR writers through E..W with their
// remaining Tnew and derives the D-stage stall, the forward selects and their E/M copies.
module hazard_fwd_tracker #(
  parameter int NREAD = 2,
  parameter int DEPTH = 3,
  parameter int TW    = 2,
  parameter int SELW  = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   d_valid,
  input  logic [4:0]             d_dst,
  input  logic [TW-1:0]          d_tnew,
  input  logic [NREAD*5-1:0]     d_rs,
  input  logic [NREAD*TW-1:0]    d_tuse,
  input  logic                   d_is_md,
  input  logic                   md_busy,
  input  logic                   md_start_e,
  output logic                   stall,
  output logic [NREAD*SELW-1:0]  sel_d,
  output logic [NREAD-1:0]       pend_d,
  output logic [NREAD*SELW-1:0]  sel_e,
  output logic [NREAD*SELW-1:0]  sel_m,
  output logic [31:0]            stall_cnt
);

  logic [DEPTH:1]        vld_q;
  logic [4:0]            dst_q  [1:DEPTH];
  logic [TW-1:0]         tnew_q [1:DEPTH];

  logic [SELW-1:0]       km  [NREAD];
  logic [TW-1:0]         tm  [NREAD];
  logic [NREAD-1:0]      hit;
  logic [NREAD-1:0]      hz;
  logic [NREAD*SELW-1:0] sel_e_d;
  logic [NREAD*SELW-1:0] sel_m_d;

  // Stage code one cycle later; anything past the last stage reads from the regfile.
  function automatic logic [SELW-1:0] nxt(input logic [SELW-1:0] k);
    nxt = (k != '0 && int'(k) < DEPTH) ? k + SELW'(1) : '0;
  endfunction

  function automatic logic [TW-1:0] dec(input logic [TW-1:0] t);
    dec = (t == '0) ? '0 : t - TW'(1);
  endfunction

  // Scan from the oldest stage down so the youngest matching producer overwrites.
  always_comb begin
    for (int i = 0; i < NREAD; i++) begin
      km[i]  = '0;
      tm[i]  = '0;
      hit[i] = 1'b0;
      for (int k = DEPTH; k >= 1; k--) begin
        if (vld_q[k] && dst_q[k] == d_rs[5*i +: 5] && d_rs[5*i +: 5] != 5'd0) begin
          km[i]  = SELW'(k);
          tm[i]  = tnew_q[k];
          hit[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_d   = '0;
    pend_d  = '0;
    hz      = '0;
    sel_e_d = '0;
    sel_m_d = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (hit[i]) begin
        if (tm[i] == '0)                       sel_d[SELW*i +: SELW] = km[i];
        else if (tm[i] <= d_tuse[TW*i +: TW])  pend_d[i] = 1'b1;
        else                                   hz[i] = 1'b1;
      end
      sel_e_d[SELW*i +: SELW] = nxt(km[i]);
      sel_m_d[SELW*i +: SELW] = nxt(sel_e[SELW*i +: SELW]);
    end
    stall = !reset && d_valid && ((|hz) || (d_is_md && (md_busy || md_start_e)));
    if (reset) begin
      sel_d  = '0;
      pend_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q     <= '0;
      sel_e     <= '0;
      sel_m     <= '0;
      stall_cnt <= '0;
    end else if (flush) begin
      vld_q <= '0;
      sel_e <= '0;
      sel_m <= '0;
    end else begin
      vld_q[1] <= !stall && d_valid && d_dst != 5'd0;
      for (int k = 1; k < DEPTH; k++) vld_q[k+1] <= vld_q[k];
      sel_e <= stall ? '0 : sel_e_d;
      sel_m <= sel_m_d;
      if (stall && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  // Payload fields are qualified by vld_q, so they need no reset.
  always_ff @(posedge clk) begin
    dst_q[1]  <= d_dst;
    tnew_q[1] <= d_tnew;
    for (int k = 1; k < DEPTH; k++) begin
      dst_q[k+1]  <= dst_q[k];
      tnew_q[k+1] <= dec(tnew_q[k]);
    end
  end

endmodule

// File: tb/tb_hazard_fwd_tracker.sv
// Directed bench for hazard_fwd_tracker: each task drives one scenario and checks inline
// against hand-computed values.
module tb_hazard_fwd_tracker;

  logic        clk = 1'b0;
  logic        reset, flush, d_valid, d_is_md, md_busy, md_start_e;
  logic [4:0]  d_dst;
  logic [1:0]  d_tnew;
  logic [9:0]  d_rs;
  logic [3:0]  d_tuse;
  logic        stall;
  logic [3:0]  sel_d, sel_e, sel_m;
  logic [1:0]  pend_d;
  logic [31:0] stall_cnt;

  int checks = 0;
  int fails  = 0;
  logic [31:0] exp_cnt = 0;

  hazard_fwd_tracker dut (
    .clk(clk), .reset(reset), .flush(flush), .d_valid(d_valid), .d_dst(d_dst),
    .d_tnew(d_tnew), .d_rs(d_rs), .d_tuse(d_tuse), .d_is_md(d_is_md),
    .md_busy(md_busy), .md_start_e(md_start_e), .stall(stall), .sel_d(sel_d),
    .pend_d(pend_d), .sel_e(sel_e), .sel_m(sel_m), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input logic v, input logic [4:0] dst, input logic [1:0] tn,
                         input logic [4:0] rs0, input logic [1:0] tu0,
                         input logic [4:0] rs1, input logic [1:0] tu1);
    d_valid = v; d_dst = dst; d_tnew = tn;
    d_rs = {rs1, rs0}; d_tuse = {tu1, tu0};
    d_is_md = 1'b0; md_busy = 1'b0; md_start_e = 1'b0;
    #1;
  endtask

  task automatic drain();
    drive_d(1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0;
    drive_d(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    d_is_md = 1'b1; md_busy = 1'b1;
    repeat (2) tick();
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %0b exp 0", stall); end
    checks++; if (sel_e !== 4'd0 || sel_m !== 4'd0 || sel_d !== 4'd0) begin fails++; $display("FAIL reset_sel got e=%0h m=%0h d=%0h exp 0", sel_e, sel_m, sel_d); end
    checks++; if (stall_cnt !== 32'd0) begin fails++; $display("FAIL reset_cnt got %0h exp 0", stall_cnt); end
    reset = 1'b0; #1;
    checks++; if (stall !== 1'b1) begin fails++; $display("FAIL md_busy_stall got %0b exp 1", stall); end
    md_busy = 1'b0; md_start_e = 1'b1; #1;
    checks++; if (stall !== 1'b1) begin fails++; $display("FAIL md_start_stall got %0b exp 1", stall); end
    d_is_md = 1'b0; #1;
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL non_md_stall got %0b exp 0", stall); end
    drain();
  endtask

  task automatic test_alu_alu();
    drive_d(1'b1, 5'd1, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0);
    tick();
    drive_d(1'b1, 5'd0, 2'd1, 5'd1, 2'd1, 5'd0, 2'd0);
    checks++; if (stall !== 1'b0) begin fails++; $display("FAIL alu_stall got %0b exp 0", stall); end
    checks++; if (pend_d[0] !== 1'b1) begin fails++; $display("FAIL alu_pend got %0b exp 1", pend_d[0]); end
    checks++; if (sel_d[1:0] !== 2'd0) begin fails++; $display("FAIL alu_sel_d got %0d exp 0", sel_d[1:0]); end
    tick();
    drive_d(1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    checks++; if (sel_e !== 4'b00_10) begin fails++; $display("FAIL alu_sel_e got %0h exp 2", sel_e); end
    tick();
    checks++; if (sel_m !== 4'b00_11) begin fails++; $display("FAIL alu_sel_m got %0h exp 3", sel_m); end
    drain();
  endtask

  task automatic test_load_use();
    drive_d(1'b1, 5'd2, 2'd2, 5'd0, 2'd0, 5'd0, 2'd0);
    tick();
    drive_d(1'b1, 5'd0, 2'd1, 5'd2, 2'd1, 5'd0, 2'd0);
    checks++; if (stall !== 1'b1) begin fails++; $display("FAIL lu_stall got %0b exp 1", stall); end
    tick(); exp_cnt = exp_cnt + 1;
    checks++; if (stall !== 1'b0 || pend_d[0] !== 1'b1) begin fails++; $display("FAIL lu_release got stall=%0b pend=%0b exp 0/1", stall, pend_d[0]); end
    checks++; if (stall_cnt !== exp_cnt) begin fails++; $display("FAIL lu_cnt got %0d exp %0d", stall_cnt, exp_cnt); end
    checks++; if (sel_e !== 4'd0) begin fails++; $display("FAIL lu_bubble_sel_e got %0h exp 0", sel_e); end
    tick();
    drive_d(1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    checks++; if (sel_e !== 4'b00_11) begin fails++; $display("FAIL lu_sel_e got %0h exp 3", sel_e); end
    drain();
  endtask

  task automatic test_branch();
    drive_d(1'b1, 5'd4, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0);
    tick();
    drive_d(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd4, 2'd0);
    checks++; if (stall !== 1'b1) begin fails++; $display("FAIL br_stall got %0b exp 1", stall); end
    tick(); exp_cnt = exp_cnt + 1;
    checks++; if (stall !== 1'b0 || sel_d !== 4'b10_00 || pend_d !== 2'b00) begin fails++; $display("FAIL br_fwd got stall=%0b sel_d=%0h pend=%0b exp 0/8/0", stall, sel_d, pend_d); end
    tick();
    drive_d(1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    checks++; if (sel_e !== 4'b11_00) begin fails++; $display("FAIL br_sel_e got %0h exp c", sel_e); end
    checks++; if (stall_cnt !== exp_cnt) begin fails++; $display("FAIL br_cnt got %0d exp %0d", stall_cnt, exp_cnt); end
    drain();
  endtask

  task automatic test_youngest();
    drive_d(1'b1, 5'd3, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0);
    tick();
    drive_d(1'b1, 5'd3, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    tick();
    drive_d(1'b1, 5'd0, 2'd2, 5'd3, 2'd1, 5'd0, 2'd0);
    checks++; if (sel_d !== 4'b00_01 || stall !== 1'b0 || pend_d !== 2'b00) begin fails++; $display("FAIL young_sel_d got sel_d=%0h stall=%0b pend=%0b exp 1/0/0", sel_d, stall, pend_d); end
    tick();
    drive_d(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd3, 2'd0);
    checks++; if (sel_d !== 4'b10_00 || pend_d !== 2'b00 || stall !== 1'b0) begin fails++; $display("FAIL r0_sel_d got sel_d=%0h pend=%0b stall=%0b exp 8/0/0", sel_d, pend_d, stall); end
    checks++; if (sel_e !== 4'b00_10) begin fails++; $display("FAIL young_sel_e got %0h exp 2", sel_e); end
    tick();
    drive_d(1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    checks++; if (sel_e !== 4'b11_00 || sel_m !== 4'b00_11) begin fails++; $display("FAIL young_pipe got e=%0h m=%0h exp c/3", sel_e, sel_m); end
    drain();
  endtask

  task automatic test_flush();
    drive_d(1'b1, 5'd1, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    tick();
    drive_d(1'b1, 5'd2, 2'd2, 5'd1, 2'd1, 5'd0, 2'd0);
    tick();
    drive_d(1'b1, 5'd0, 2'd1, 5'd2, 2'd1, 5'd0, 2'd0);
    flush = 1'b1; #1;
    checks++; if (stall !== 1'b1 || sel_e !== 4'b00_10) begin fails++; $display("FAIL flush_pre got stall=%0b sel_e=%0h exp 1/2", stall, sel_e); end
    tick();
    flush = 1'b0; #1;
    checks++; if (stall !== 1'b0 || pend_d !== 2'b00 || sel_d !== 4'd0) begin fails++; $display("FAIL flush_stall got stall=%0b pend=%0b sel_d=%0h exp 0/0/0", stall, pend_d, sel_d); end
    checks++; if (sel_e !== 4'd0 || sel_m !== 4'd0) begin fails++; $display("FAIL flush_sel got e=%0h m=%0h exp 0/0", sel_e, sel_m); end
    checks++; if (stall_cnt !== exp_cnt) begin fails++; $display("FAIL flush_cnt got %0d exp %0d", stall_cnt, exp_cnt); end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    drive_d(1'b1, 5'd7, 2'd2, 5'd0, 2'd0, 5'd0, 2'd0);
    tick();
    drive_d(1'b1, 5'd0, 2'd0, 5'd7, 2'd0, 5'd0, 2'd0);
    checks++; if (stall !== 1'b1) begin fails++; $display("FAIL rms_pre got %0b exp 1", stall); end
    reset = 1'b1; #1;
    checks++; if (stall !== 1'b0 || sel_d !== 4'd0 || pend_d !== 2'd0) begin fails++; $display("FAIL rms_stall got stall=%0b sel_d=%0h pend=%0b exp 0", stall, sel_d, pend_d); end
    tick(); exp_cnt = 0;
    reset = 1'b0; #1;
    checks++; if (stall_cnt !== exp_cnt || stall !== 1'b0) begin fails++; $display("FAIL rms_cnt got cnt=%0d stall=%0b exp 0/0", stall_cnt, stall); end
    drain();
  endtask

  task automatic test_saturate();
    drive_d(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    d_is_md = 1'b1; md_busy = 1'b1;
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    tick();
    checks++; if (stall_cnt !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sat_reach got %0h exp ffffffff", stall_cnt); end
    tick();
    checks++; if (stall_cnt !== 32'hFFFF_FFFF || stall !== 1'b1) begin fails++; $display("FAIL sat_hold got cnt=%0h stall=%0b exp ffffffff/1", stall_cnt, stall); end
    drain();
  endtask

  initial begin
    test_reset();
    test_alu_alu();
    test_load_use();
    test_branch();
    test_youngest();
    test_flush();
    test_reset_mid_stall();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_tracker.md
# hazard_fwd_tracker

Parametrised hazard/forwarding tracker for the pipelined MIPS core. It replaces per-mux hard-coded select logic with a registered producer scoreboard. Every instruction that writes a GPR is tracked through stages E..W together with its remaining Tnew. From that state the block computes, for each source read port:
- the stall request at D;
- the forwarding select at D;
- the registered forwarding selects that travel with the consumer into E and M.

Its outputs drive the MFCMP/MFALU/MFDM-style data muxes and the F/D stall/bubble controls.

## Interface
Parameters:
- NREAD, 2: number of GPR source ports read in D.
- DEPTH, 3: number of producer stages after D (1=E, 2=M, 3=W).
- TW, 2: width of Tnew/Tuse fields.
- SELW, $clog2(DEPTH+1): width of a stage-select code.

Ports:
- clk  in  1  core clock. One clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  exception/eret flush. Clears all tracked state.
- d_valid  in  1  the D-stage instruction is real (not a bubble).
- d_dst  in  5  GPR written by the D instruction (0 = no write).
- d_tnew  in  TW  cycles after E-entry until the result can be forwarded (jal 0, ALU 1, load 2).
- d_rs  in  NREAD*5  source register numbers, port i at [5i+4:5i].
- d_tuse  in  NREAD*TW  cycles from D until port i's value is needed (branch 0, ALU 1, store data 2).
- d_is_md  in  1  the D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- md_busy  in  1  the MD unit is busy.
- md_start_e  in  1  a mult/div is in E this cycle.
- stall  out  1  freeze PC and F/D, insert bubble into E.
- sel_d  out  NREAD*SELW  D-stage forward source per port (0 = regfile, k = stage k).
- pend_d  out  NREAD  producer found but not yet ready; no stall needed.
- sel_e  out  NREAD*SELW  registered forward select for the consumer now in E.
- sel_m  out  NREAD*SELW  registered forward select for the consumer now in M.
- stall_cnt  out  32  saturating count of stall cycles.

## Operation
Producer entries:
- Each entry k (1..DEPTH) holds {valid, dst[4:0], tnew[TW-1:0]}.

Entry update each cycle, in priority order reset > flush > normal:
- reset or flush: all entries invalid; sel_e/sel_m cleared to 0; stall_cnt cleared on reset only.
- Entry 1 (E):
  - stall=1: becomes a bubble.
  - otherwise: loads {d_valid && d_dst!=0, d_dst, d_tnew}.
- Entry k+1 ← entry k, with tnew ← (tnew==0) ? 0 : tnew−1.
- The entry leaving DEPTH is dropped, because the regfile holds its value next cycle.

Per-port match (combinational), for port i:
- Find the lowest k with valid_k && dst_k==rs_i && rs_i!=0. The youngest producer wins.
- If there is no match: sel_d=0, pend_d=0, no hazard.
- If tnew_k==0: sel_d=k, pend_d=0.
- If 0 < tnew_k ≤ tuse_i: sel_d=0, pend_d=1.
- If tnew_k > tuse_i: data hazard on this port.

Stall:
- stall = d_valid && ((OR of per-port data hazards) || (d_is_md && (md_busy || md_start_e))).
- stall is forced to 0 while reset=1.

Consumer select pipeline:
- For each port, let nxt(k) = (k==0 || k+1>DEPTH) ? 0 : k+1.
- When stall=0, sel_e ← nxt(k_match); with no match it is 0. This holds whether the match is ready or pending.
- When stall=1, sel_e ← 0 (bubble).
- Every cycle, sel_m ← nxt(sel_e).

stall_cnt:
- Increments when stall=1 and the count is below 0xFFFFFFFF; otherwise it holds.

Other rules:
- A producer with dst=0 is never tracked, and r0 never matches.
- Tnew/Tuse arithmetic is unsigned over TW bits.

## Timing
- stall, sel_d and pend_d are combinational from the current entries and D inputs. They are valid in the same cycle with no register delay.
- sel_e/sel_m: one and two cycles after the consumer leaves D, aligned with the consumer's arrival in E and M.
- Reset values: all entries invalid, sel_e=sel_m=0, stall_cnt=0. While reset is high, stall=0 and sel_d=pend_d=0.
- Flush and stall in the same cycle: flush wins. Entries clear and the next-cycle stall re-evaluates from empty.
- Reset mid-stall: stall drops in the same cycle; no stall_cnt increment.
- Load-use stalls last exactly tnew−tuse cycles; each cycle of stall lowers the producer's tnew by 1.

## Test plan
- Reset: hold reset 2 cycles with md_busy=1 → stall=0, all sel=0, stall_cnt=0. Release → stall=1 only if d_is_md=1.
- ALU→ALU: cycle0 D {dst=1, tnew=1}; cycle1 D rs0=1, tuse0=1 → stall=0, pend_d0=1, sel_d0=0. Cycle2 → sel_e0=2. Cycle3 → sel_m0=3.
- Load-use: D {dst=2, tnew=2}, then D rs0=2, tuse0=1 → stall=1 for 1 cycle, stall_cnt=1. Next cycle → stall=0, pend_d0=1. Following cycle → sel_e0=3.
- Branch after ALU: D {dst=4, tnew=1}, then beq rs1=4, tuse1=0 → 1 stall cycle, then sel_d1=2.
- Youngest wins: $3 written by an ALU op (now in M, tnew=0) and by jal (now in E, tnew=0) → sel_d=1. rs=0 with entry dst=0 → sel_d=0.
- Flush during load-use stall → stall=0 next cycle, sel_e=sel_m=0, stall_cnt holds. stall_cnt preloaded to 0xFFFFFFFF with stall=1 → stays at 0xFFFFFFFF.
